regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file with a pending-write scoreboard and a

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, writeback, allocation and ready.
// The master side is decode/writeback; the slave side is the register file.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic                   ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard and post-reset clear sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding; default is read-old.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // state | meaning
    // CLEAR | zeroing storage one entry per edge, ports dead
    // RUN   | clear done, reads/writes/allocs live
    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic              wr_ok;
    logic              alloc_ok;

    always_comb begin
        wr_ok     = ready_q && bus.wr_en && (bus.wr_addr != '0);
        alloc_ok  = ready_q && bus.alloc_en && (bus.alloc_addr != '0);
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_ok) begin
                    mem_we            = 1'b1;
                    mem_waddr         = bus.wr_addr;
                    mem_wdata         = bus.wr_data;
                    busy_d[bus.wr_addr] = 1'b0;
                end
                // Allocation is applied after the write so a new producer wins.
                if (alloc_ok) begin
                    busy_d[bus.alloc_addr] = 1'b1;
                end
            end
        endcase
        busy_d[0] = 1'b0;
        ready_d   = (state_d == RUN);
        // Reset must never disturb storage.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]      rd_busy_c;
    logic [AW-1:0]          rd_a;

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        rd_a      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_a = bus.rd_addr[p*AW +: AW];
            if (ready_q && (rd_a != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (bus.wr_en && (bus.wr_addr == rd_a)) begin
                    rd_data_c[p*XLEN +: XLEN] = bus.wr_data;
                    rd_busy_c[p]              = 1'b0;
                end else begin
                    rd_data_c[p*XLEN +: XLEN] = mem_q[rd_a];
                    rd_busy_c[p]              = busy_q[rd_a];
                end
`else
                rd_data_c[p*XLEN +: XLEN] = mem_q[rd_a];
                rd_busy_c[p]              = busy_q[rd_a];
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-based reference model,
// plus a second 4-port/16-entry instance for the wide-port configuration.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int ND   = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NR), .NUM_RD(ND)) bus1 ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(16), .NUM_RD(4))  bus2 ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NR), .NUM_RD(ND)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    regfile_mp #(.XLEN(XLEN), .NREGS(16), .NUM_RD(4))  dut2 (
        .clk(clk), .rst_n(rst_n2), .bus(bus2));

    int n_err = 0;
    int n_chk = 0;

    // Reference model: edges since reset release, storage and pending bits.
    int          m_cnt = 0;
    logic [31:0] m_mem [NR];
    logic        m_busy [NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_cnt = 0;
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (m_cnt < NR) begin
            m_cnt++;
            if (m_cnt == NR) for (int i = 0; i < NR; i++) m_mem[i] = '0;
        end else begin
            if (bus1.wr_en && bus1.wr_addr != 0) begin
                m_mem[bus1.wr_addr]  = bus1.wr_data;
                m_busy[bus1.wr_addr] = 1'b0;
            end
            if (bus1.alloc_en && bus1.alloc_addr != 0) m_busy[bus1.alloc_addr] = 1'b1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        logic [AW-1:0] a;
        logic [31:0]   ed;
        logic          eb;
        check({tag, "_rdy"}, 64'(bus1.ready), 64'(m_cnt >= NR));
        for (int p = 0; p < ND; p++) begin
            a  = bus1.rd_addr[p*AW +: AW];
            ed = '0;
            eb = 1'b0;
            if (m_cnt >= NR && a != 0) begin
`ifdef REGFILE_BYPASS_EN
                if (bus1.wr_en && bus1.wr_addr == a) begin
                    ed = bus1.wr_data;
                    eb = 1'b0;
                end else begin
                    ed = m_mem[a];
                    eb = m_busy[a];
                end
`else
                ed = m_mem[a];
                eb = m_busy[a];
`endif
            end
            check($sformatf("%s_d%0d", tag, p), 64'(bus1.rd_data[p*XLEN +: XLEN]), 64'(ed));
            check($sformatf("%s_b%0d", tag, p), 64'(bus1.rd_busy[p]), 64'(eb));
        end
    endtask

    task automatic idle1();
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
        bus1.alloc_en = 1'b0; bus1.alloc_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus1.rd_addr = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        idle1();
        bus1.rd_addr = '0;
        bus2.rd_addr = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.alloc_en = 1'b0; bus2.alloc_addr = '0;
        #1;

        // Reset, then ready after exactly NR edges; reads return 0 meanwhile.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        set_rd(5'd3, 5'd17);
        for (int i = 0; i <= NR; i++) begin
            check("t1_ready", 64'(bus1.ready), 64'(i == NR));
            check_reads("t1_clr");
            if (i < NR) step();
        end
        for (int a = 0; a < NR; a++) begin
            set_rd(AW'(a), AW'(NR - 1 - a)); #1;
            check("t1_zero", 64'(bus1.rd_data[31:0]), 64'd0);
            check_reads("t1_all");
        end

        // x5 write, two ports read it; write to x0 dropped.
        set_rd(5'd5, 5'd5);
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd5; bus1.wr_data = 32'hDEADBEEF; #1;
        check_reads("t2_wr"); step(); idle1(); #1;
        check("t2_p0", 64'(bus1.rd_data[31:0]), 64'hDEADBEEF);
        check("t2_p1", 64'(bus1.rd_data[63:32]), 64'hDEADBEEF);
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd0; bus1.wr_data = 32'h1234; step(); idle1();
        set_rd(5'd0, 5'd0); #1;
        check("t2_x0", 64'(bus1.rd_data), 64'd0);
        check_reads("t2_x0m");

        // Scoreboard: alloc sets, write clears, same-cycle alloc+write ends busy.
        bus1.alloc_en = 1'b1; bus1.alloc_addr = 5'd7; step(); idle1();
        set_rd(5'd7, 5'd0); #1;
        check("t3_busy7", 64'(bus1.rd_busy), 64'b01);
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd7; bus1.wr_data = 32'h55; step(); idle1(); #1;
        check("t3_clr7", 64'(bus1.rd_busy), 64'b00);
        check("t3_d7", 64'(bus1.rd_data[31:0]), 64'h55);
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd9; bus1.wr_data = 32'hA;
        bus1.alloc_en = 1'b1; bus1.alloc_addr = 5'd9; step(); idle1();
        set_rd(5'd9, 5'd9); #1;
        check("t3_d9", 64'(bus1.rd_data[31:0]), 64'hA);
        check("t3_b9", 64'(bus1.rd_busy), 64'b11);

        // Write-first vs read-old on x3.
        set_rd(5'd3, 5'd1);
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd3; bus1.wr_data = 32'h77; #1;
`ifdef REGFILE_BYPASS_EN
        check("t5_same", 64'(bus1.rd_data[31:0]), 64'h77);
`else
        check("t5_same", 64'(bus1.rd_data[31:0]), 64'h0);
`endif
        check_reads("t5_m"); step(); idle1(); #1;
        check("t5_next", 64'(bus1.rd_data[31:0]), 64'h77);

        // Randomized traffic, biased to a few registers to exercise busy collisions.
        for (int c = 0; c < 300; c++) begin
            bus1.wr_en      = ($urandom_range(0, 1) == 1);
            bus1.wr_addr    = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
            bus1.wr_data    = $urandom;
            bus1.alloc_en   = ($urandom_range(0, 2) == 0);
            bus1.alloc_addr = AW'($urandom_range(0, 7));
            set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
            #1;
            check_reads("rnd");
            step();
        end
        idle1(); #1;
        check_reads("rnd_end");

        // Reset during CLEAR restarts; wr/alloc during CLEAR ignored.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd6; bus1.wr_data = 32'h99;
        bus1.alloc_en = 1'b1; bus1.alloc_addr = 5'd6;
        set_rd(5'd6, 5'd9);
        for (int i = 0; i <= NR; i++) begin
            check("t4_ready", 64'(bus1.ready), 64'(i == NR));
            if (i < NR) step();
        end
        idle1(); #1;
        check("t4_x6", 64'(bus1.rd_data[31:0]), 64'h0);
        check("t4_b6", 64'(bus1.rd_busy), 64'b00);
        check_reads("t4_m");

        // Four ports on a 16-entry instance.
        rst_n2 = 1'b0; step(); rst_n2 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            check("t6_ready", 64'(bus2.ready), 64'(i == 16));
            if (i < 16) step();
        end
        for (int r = 1; r <= 4; r++) begin
            bus2.wr_en = 1'b1; bus2.wr_addr = 4'(r); bus2.wr_data = 32'(r);
            step();
        end
        bus2.wr_en = 1'b0;
        bus2.rd_addr = {4'd4, 4'd3, 4'd2, 4'd1}; #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("t6_p%0d", p), 64'(bus2.rd_data[p*32 +: 32]), 64'(p + 1));
        bus2.rd_addr = {4'd2, 4'd2, 4'd0, 4'd2}; #1;
        check("t6_same", 64'(bus2.rd_data), {32'd2, 32'd2, 32'd0, 32'd2} & 128'hFFFF_FFFF_FFFF_FFFF);
        check("t6_hi", 64'(bus2.rd_data[127:64]), {32'd2, 32'd2});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
